// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: pad, requester and status signals of the two-master I2C bus arbiter
interface i2c_bus_arbiter_if;
  logic       sda_in, scl_in, sda_oe, scl_oe;
  logic       m0_req, m1_req, m0_gnt, m1_gnt;
  logic       m0_sda_oe, m0_scl_oe, m1_sda_oe, m1_scl_oe;
  logic       m0_sda_in, m0_scl_in, m1_sda_in, m1_scl_in;
  logic       bus_busy, timeout_err;
  logic [1:0] owner;
  modport master (
    output sda_in, scl_in, m0_req, m1_req, m0_sda_oe, m0_scl_oe, m1_sda_oe, m1_scl_oe,
    input  sda_oe, scl_oe, m0_gnt, m1_gnt, m0_sda_in, m0_scl_in, m1_sda_in, m1_scl_in,
    input  bus_busy, timeout_err, owner
  );
  modport slave (
    input  sda_in, scl_in, m0_req, m1_req, m0_sda_oe, m0_scl_oe, m1_sda_oe, m1_scl_oe,
    output sda_oe, scl_oe, m0_gnt, m1_gnt, m0_sda_in, m0_scl_in, m1_sda_in, m1_scl_in,
    output bus_busy, timeout_err, owner
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one open-drain I2C bus between two masters, grant held until STOP, stuck-SCL recovery
module i2c_bus_arbiter #(
  parameter int IDLE_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clk_clk,
  input logic             reset_reset_n,
  i2c_bus_arbiter_if.slave bus
);
  localparam int FW = $clog2(IDLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FREE_T  = FW'(IDLE_CYCLES);
  localparam logic [TW-1:0] STUCK_T = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FAULT} state_t;
  state_t state, state_n;
  logic sda_m, scl_m, sda_s, scl_s, sda_d;
  logic busy, last, last_n, tout;
  logic [FW-1:0] free_cnt;
  logic [TW-1:0] stuck_cnt;
  logic start, stop, bus_free, granted, stuck_hit, own_req, fault_req, pick1;
  assign start     = scl_s & sda_d & ~sda_s;
  assign stop      = scl_s & ~sda_d & sda_s;
  assign bus_free  = free_cnt == FREE_T;
  assign granted   = (state == GRANT0) | (state == GRANT1);
  assign stuck_hit = granted & ~scl_s & (stuck_cnt == STUCK_T);
  assign own_req   = (state == GRANT1) ? bus.m1_req : bus.m0_req;
  assign fault_req = last ? bus.m1_req : bus.m0_req;
  assign pick1     = bus.m1_req & (~bus.m0_req | ~last);
  // Synchronizers, bus condition tracking, free/stuck counters and FSM state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sda_m     <= 1'b0;
      scl_m     <= 1'b0;
      sda_s     <= 1'b0;
      scl_s     <= 1'b0;
      sda_d     <= 1'b0;
      busy      <= 1'b0;
      free_cnt  <= '0;
      stuck_cnt <= '0;
      state     <= IDLE;
      last      <= 1'b1;
      tout      <= 1'b0;
    end else begin
      sda_m     <= bus.sda_in;
      scl_m     <= bus.scl_in;
      sda_s     <= sda_m;
      scl_s     <= scl_m;
      sda_d     <= sda_s;
      busy      <= stuck_hit ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : busy;
      free_cnt  <= (state == IDLE && !busy && sda_s && scl_s) ? (bus_free ? free_cnt : free_cnt + 1'b1) : '0;
      stuck_cnt <= (granted && !scl_s) ? (stuck_hit ? stuck_cnt : stuck_cnt + 1'b1) : '0;
      state     <= state_n;
      last      <= last_n;
      tout      <= stuck_hit;
    end
  end
  // Next state: grant on a free bus, release only between transfers, timeout overrides release
  always_comb begin
    state_n = state;
    last_n  = last;
    case (state)
      IDLE:    if (bus_free && (bus.m0_req || bus.m1_req)) state_n = pick1 ? GRANT1 : GRANT0;
      FAULT:   if (!fault_req) state_n = IDLE;
      default: if (stuck_hit || (!own_req && !busy)) begin
        state_n = stuck_hit ? FAULT : IDLE;
        last_n  = state == GRANT1;
      end
    endcase
  end
  assign bus.m0_gnt      = state == GRANT0;
  assign bus.m1_gnt      = state == GRANT1;
  assign bus.owner       = {state == GRANT1, state == GRANT0};
  assign bus.sda_oe      = (state == GRANT0) ? bus.m0_sda_oe : (state == GRANT1) ? bus.m1_sda_oe : 1'b0;
  assign bus.scl_oe      = (state == GRANT0) ? bus.m0_scl_oe : (state == GRANT1) ? bus.m1_scl_oe : 1'b0;
  assign bus.m0_sda_in   = bus.sda_in;
  assign bus.m0_scl_in   = bus.scl_in;
  assign bus.m1_sda_in   = bus.sda_in;
  assign bus.m1_scl_in   = bus.scl_in;
  assign bus.bus_busy    = busy;
  assign bus.timeout_err = tout;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed vectors and hand-timed sequences for the I2C bus arbiter
module tb_i2c_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  i2c_bus_arbiter_if bus();
  i2c_bus_arbiter #(.IDLE_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic m0s, m0c, m1s, m1c;
    logic es, ec;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic sel(input int s);
    return (s == 0) ? bus.m0_gnt : (s == 1) ? bus.m1_gnt : (s == 2) ? bus.bus_busy : bus.timeout_err;
  endfunction
  task automatic wait_lvl(input int s, input logic lvl, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (sel(s) == lvl) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    int got;
    vt[0] = '{0, 0, 1, 1, 0, 0};
    vt[1] = '{1, 0, 1, 0, 1, 0};
    vt[2] = '{0, 1, 0, 1, 0, 1};
    vt[3] = '{1, 1, 0, 0, 1, 1};
    vt[4] = '{0, 0, 1, 0, 0, 0};
    vt[5] = '{1, 0, 0, 1, 1, 0};
    rst_n = 1'b0;
    bus.sda_in = 1'b1;
    bus.scl_in = 1'b1;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    bus.m0_sda_oe = 1'b1;
    bus.m0_scl_oe = 1'b0;
    bus.m1_sda_oe = 1'b0;
    bus.m1_scl_oe = 1'b1;
    repeat (3) tick();
    chk("rst_owner", bus.owner, 0);
    chk("rst_m0_gnt", bus.m0_gnt, 0);
    chk("rst_m1_gnt", bus.m1_gnt, 0);
    chk("rst_busy", bus.bus_busy, 0);
    chk("rst_tout", bus.timeout_err, 0);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_scl_oe", bus.scl_oe, 0);
    bus.m0_sda_oe = 1'b0;
    bus.m1_scl_oe = 1'b0;
    rst_n = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("reset_grant_lat", n, 11);
    chk("first_tie_owner", bus.owner, 1);
    chk("first_tie_m1_gnt", bus.m1_gnt, 0);
    bus.m0_sda_oe = 1'b1;
    #1;
    chk("oe_same_cycle", bus.sda_oe, 1);
    for (int i = 0; i < 6; i++) begin
      bus.m0_sda_oe = vt[i].m0s;
      bus.m0_scl_oe = vt[i].m0c;
      bus.m1_sda_oe = vt[i].m1s;
      bus.m1_scl_oe = vt[i].m1c;
      #1;
      chk($sformatf("mux_sda[%0d]", i), bus.sda_oe, vt[i].es);
      chk($sformatf("mux_scl[%0d]", i), bus.scl_oe, vt[i].ec);
    end
    bus.m0_sda_oe = 1'b0;
    bus.m0_scl_oe = 1'b0;
    bus.m1_sda_oe = 1'b0;
    bus.m1_scl_oe = 1'b0;
    tick();
    bus.sda_in = 1'b0;
    wait_lvl(2, 1'b1, n);
    chk("start_lat", n, 3);
    chk("copy_m0_sda", bus.m0_sda_in, 0);
    chk("copy_m1_sda", bus.m1_sda_in, 0);
    chk("copy_m1_scl", bus.m1_scl_in, 1);
    bus.sda_in = 1'b1;
    wait_lvl(2, 1'b0, n);
    chk("stop_lat", n, 3);
    bus.m0_req = 1'b0;
    wait_lvl(0, 1'b0, n);
    chk("release_lat", n, 1);
    wait_lvl(1, 1'b1, n);
    chk("m1_after_idle", n, 9);
    chk("m1_owner", bus.owner, 2);
    tick();
    bus.sda_in = 1'b0;
    wait_lvl(2, 1'b1, n);
    chk("m1_start_lat", n, 3);
    bus.m1_req = 1'b0;
    repeat (5) tick();
    chk("hold_mid_transfer", bus.m1_gnt, 1);
    bus.sda_in = 1'b1;
    wait_lvl(2, 1'b0, n);
    chk("m1_stop_lat", n, 3);
    chk("gnt_at_stop", bus.m1_gnt, 1);
    tick();
    chk("release_after_stop", bus.m1_gnt, 0);
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("rr_m0_again", n, 9);
    chk("rr_m0_again_m1", bus.m1_gnt, 0);
    bus.m0_req = 1'b0;
    tick();
    chk("m0_drop", bus.m0_gnt, 0);
    bus.m0_req = 1'b1;
    wait_lvl(1, 1'b1, n);
    chk("rr_m1_tie", n, 9);
    chk("rr_m1_tie_m0", bus.m0_gnt, 0);
    bus.m1_req = 1'b0;
    tick();
    chk("m1_drop", bus.m1_gnt, 0);
    bus.sda_in = 1'b0;
    wait_lvl(2, 1'b1, n);
    chk("ext_start_lat", n, 3);
    got = 0;
    repeat (20) begin
      tick();
      got |= int'(bus.m0_gnt);
    end
    chk("ext_no_grant", got, 0);
    bus.sda_in = 1'b1;
    wait_lvl(2, 1'b0, n);
    chk("ext_stop_lat", n, 3);
    wait_lvl(0, 1'b1, n);
    chk("ext_grant_after_stop", n, 9);
    bus.m0_scl_oe = 1'b1;
    #1;
    chk("own_scl_oe", bus.scl_oe, 1);
    tick();
    bus.sda_in = 1'b0;
    wait_lvl(2, 1'b1, n);
    chk("stuck_start_lat", n, 3);
    bus.scl_in = 1'b0;
    wait_lvl(3, 1'b1, n);
    chk("timeout_lat", n, 66);
    chk("fault_m0_gnt", bus.m0_gnt, 0);
    chk("fault_scl_oe", bus.scl_oe, 0);
    chk("fault_busy", bus.bus_busy, 0);
    chk("fault_owner", bus.owner, 0);
    tick();
    chk("timeout_pulse", bus.timeout_err, 0);
    bus.scl_in = 1'b1;
    repeat (2) tick();
    bus.sda_in = 1'b1;
    repeat (20) tick();
    chk("fault_holds", bus.m0_gnt, 0);
    bus.m0_req = 1'b0;
    tick();
    bus.m0_req = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("regrant_after_fault", n, 9);
    bus.scl_in = 1'b0;
    repeat (65) tick();
    bus.m0_req = 1'b0;
    tick();
    chk("timeout_wins", bus.timeout_err, 1);
    chk("timeout_wins_gnt", bus.m0_gnt, 0);
    tick();
    bus.scl_in = 1'b1;
    bus.m0_req = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("regrant_after_race", n, 11);
    bus.m0_sda_oe = 1'b1;
    #1;
    chk("pre_reset_sda_oe", bus.sda_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sda_oe", bus.sda_oe, 0);
    chk("async_rst_scl_oe", bus.scl_oe, 0);
    chk("async_rst_owner", bus.owner, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("requalify_lat", n, 11);
    chk("requalify_sda_oe", bus.sda_oe, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
